// File: rtl/user_lock_pkg.sv
// Shared types and constants for the user-locked register bank.
// The write side imports READ_USR_DEF so both sides agree on the authorised reader.
package user_lock_pkg;

    typedef logic [1:0] usr_id_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RESP
    } rd_state_t;

    localparam int      NUM_USR      = 4;
    localparam usr_id_t READ_USR_DEF = 2'h2;

endpackage

// File: rtl/user_fail_counter.sv
// Per-user count of consecutive denied reads. Saturates at MAX_FAIL and
// raises a sticky lock flag; only reset clears the lock.
module user_fail_counter #(
    parameter int MAX_FAIL = 3,
    parameter int CNT_W    = $clog2(MAX_FAIL + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic lock_o
);

    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_FAIL);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MAX_FAIL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             lock_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            lock_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && cnt_q != MAX_C) begin
            cnt_q <= cnt_q + CNT_W'(1);
            // lock in the same cycle the count reaches MAX_FAIL
            if (cnt_q == LAST_C)
                lock_q <= 1'b1;
        end
    end

    assign lock_o = lock_q;

endmodule

// File: rtl/user_locked_read_port.sv
// Access-controlled read port: only READ_USR gets register data; other IDs
// get err with zero data and accumulate failures towards a sticky lockout.
module user_locked_read_port
    import user_lock_pkg::*;
#(
    parameter int      DATA_W   = 8,
    parameter int      DEPTH    = 4,
    parameter int      ADDR_W   = 2,
    parameter usr_id_t READ_USR = READ_USR_DEF,
    parameter int      MAX_FAIL = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_usr_id,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DEPTH*DATA_W-1:0] reg_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic [NUM_USR-1:0]      lock_status
);

    rd_state_t          state_q;
    usr_id_t            usr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic               rsp_err_q;
    logic [NUM_USR-1:0] lock_w;

    logic [DATA_W-1:0]  sel_data;
    logic               in_range;
    logic               usr_locked;
    logic               is_reader;
    logic               grant;
    logic               fail_inc;
    logic               fail_clr;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < DEPTH; i++)
            if (int'(addr_q) == i)
                sel_data = reg_data[i*DATA_W +: DATA_W];
        in_range   = int'(addr_q) < DEPTH;
        usr_locked = lock_w[usr_q];
        is_reader  = (usr_q == READ_USR);
        grant      = in_range && !usr_locked && is_reader;
        fail_inc   = (state_q == CHECK) && in_range && !usr_locked && !is_reader;
        fail_clr   = (state_q == CHECK) && grant;
    end

    for (genvar u = 0; u < NUM_USR; u++) begin : g_fail
        user_fail_counter #(.MAX_FAIL(MAX_FAIL)) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc_i  (fail_inc && usr_q == usr_id_t'(u)),
            .clr_i  (fail_clr && usr_q == usr_id_t'(u)),
            .lock_o (lock_w[u])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            usr_q       <= '0;
            addr_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        usr_q       <= req_usr_id;
                        addr_q      <= req_addr;
                        req_ready_q <= 1'b0;
                        state_q     <= CHECK;
                    end
                end
                CHECK: begin
                    rsp_data_q  <= grant ? sel_data : '0;
                    rsp_err_q   <= !grant;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    // ready stays low through the handshake cycle, so a
                    // request arriving alongside it waits for the next IDLE
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign lock_status = lock_w;

endmodule
